im_loader: RTL

- Writer side of the instruction memory: receives a byte-stream program image and emits 32-bit word writes to the instruction memory's write port.
- Assembles little-endian words, generates byte addresses word_idx*4, checks the image length and an XOR checksum.
- Holds the CPU in reset (cpu_hold) while loading, so the fetch side never reads a partly written program.

---
 rtl/im_loader_pkg.sv | 19 +
 rtl/im_loader_if.sv | 33 +++
 rtl/im_word_packer.sv | 48 ++++
 rtl/im_loader.sv | 124 ++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Imported by the loader, its interface and the fetch side.
package im_loader_pkg;

    localparam int IM_ADDR_W = 14;
    localparam int IM_WORDS  = 43;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input, imem write port and status of the loader.
// master = loader side, slave = host / memory side.
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W
);

    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    modport master (
        input  start, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata,
        output busy, done, err, cpu_hold
    );

    modport slave (
        output start, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata,
        input  busy, done, err, cpu_hold
    );

endinterface

// File: rtl/im_word_packer.sv
// Little-endian byte-to-word packer with lane counter and XOR checksum.
// The word register is held between loads; only lane and chk are cleared.
module im_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  chk_o,
    output logic        last_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  chk_q, chk_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            lane_q <= '0;
            chk_q  <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            chk_q  <= chk_d;
        end
    end

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        chk_d  = chk_q;
        if (clr_i) begin
            lane_d = '0;
            chk_d  = '0;
        end else if (en_i) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_i;
            chk_d  = chk_q ^ byte_i;
            lane_d = lane_q + 2'd1;
        end
    end

    assign word_o = word_q;
    assign chk_o  = chk_q;
    assign last_o = en_i && (lane_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: parses len/data/checksum byte stream,
// issues word writes and holds the CPU in reset until a good image lands.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W    = IM_ADDR_W,
    parameter int MAX_WORDS = IM_WORDS
) (
    input logic         clk,
    input logic         rst_n,
    im_loader_if.master bus
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d, len_new;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              fire, busy;
    logic              pk_clr, pk_en, pk_last;
    logic [7:0]        pk_chk;
    logic [31:0]       pk_word;

    assign fire    = bus.byte_valid && bus.byte_ready;
    assign len_new = {bus.byte_in, len_q[7:0]};

    im_word_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (pk_clr),
        .en_i   (pk_en),
        .byte_i (bus.byte_in),
        .word_o (pk_word),
        .chk_o  (pk_chk),
        .last_o (pk_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        waddr_d        = waddr_q;
        pk_clr         = 1'b0;
        pk_en          = 1'b0;
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d = LEN0;
                    len_d   = '0;
                    idx_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            LEN0: begin
                bus.byte_ready = 1'b1;
                if (fire) begin
                    len_d[7:0] = bus.byte_in;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                bus.byte_ready = 1'b1;
                if (fire) begin
                    len_d = len_new;
                    if (len_new > 16'(MAX_WORDS))
                        state_d = ERR;
                    else if (len_new == 16'd0)
                        state_d = CHK;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                bus.byte_ready = 1'b1;
                pk_en          = fire;
                if (pk_last) begin
                    state_d = WRITE;
                    waddr_d = ADDR_W'(idx_q) << 2;
                end
            end
            WRITE: begin
                bus.we = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                if (16'(idx_q) + 16'd1 == len_q)
                    state_d = CHK;
                else
                    state_d = DATA;
            end
            CHK: begin
                bus.byte_ready = 1'b1;
                if (fire)
                    state_d = (bus.byte_in == pk_chk) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = state_q inside {LEN0, LEN1, DATA, WRITE, CHK};
    assign bus.busy     = busy;
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == ERR);
    // An aborted image keeps the CPU parked
    assign bus.cpu_hold = busy || (state_q == ERR);
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = pk_word;

endmodule
